// File: rtl/axis_demux.sv
// One-to-two AXI4-Stream demultiplexer: whole packets are steered to output 0 or 1
// by sel sampled on the first beat, through a one-entry holding register.
//
// state     | meaning
// ST_IDLE   | between packets; next accepted beat starts a packet and samples sel
// ST_LOCKED | inside a packet; beats follow lock_dest until TLAST
module axis_demux #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [DATA_WIDTH-1:0] DATA_in,
    input  logic                  TVALID_in,
    input  logic                  TLAST_in,
    output logic                  TREADY_in,
    input  logic                  sel,
    output logic [DATA_WIDTH-1:0] DATA_out_0,
    output logic [DATA_WIDTH-1:0] DATA_out_1,
    output logic                  TVALID_out_0,
    output logic                  TVALID_out_1,
    output logic                  TLAST_out_0,
    output logic                  TLAST_out_1,
    input  logic                  TREADY_out_0,
    input  logic                  TREADY_out_1,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_1
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    lock_dest_q, lock_dest_d;
    logic                    rst_done_q, rst_done_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    hold_last_q, hold_last_d;
    logic                    hold_dest_q, hold_dest_d;
    logic [CNT_WIDTH-1:0]    cnt_0_q, cnt_0_d;
    logic [CNT_WIDTH-1:0]    cnt_1_q, cnt_1_d;

    logic                    dest_ready;
    logic                    ready_in;
    logic                    accept;
    logic                    out_hs;
    logic                    beat_dest;

    // Downstream ready feeds upstream ready combinationally so a draining beat
    // and a new beat can share one edge.
    assign dest_ready = hold_dest_q ? TREADY_out_1 : TREADY_out_0;
    assign ready_in   = rst_done_q && (!hold_valid_q || dest_ready);
    assign accept     = TVALID_in && ready_in;
    assign out_hs     = hold_valid_q && dest_ready;
    assign beat_dest  = (state_q == ST_IDLE) ? sel : lock_dest_q;

    always_comb begin
        state_d      = state_q;
        lock_dest_d  = lock_dest_q;
        rst_done_d   = 1'b1;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_dest_d  = hold_dest_q;
        cnt_0_d      = cnt_0_q;
        cnt_1_d      = cnt_1_q;

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = DATA_in;
            hold_last_d  = TLAST_in;
            hold_dest_d  = beat_dest;
            case (state_q)
                ST_IDLE: begin
                    lock_dest_d = sel;
                    state_d     = TLAST_in ? ST_IDLE : ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (TLAST_in) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (out_hs) begin
            hold_valid_d = 1'b0;
        end

        if (out_hs && hold_last_q) begin
            if (hold_dest_q) begin
                cnt_1_d = cnt_1_q + 1'b1;
            end else begin
                cnt_0_d = cnt_0_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            lock_dest_q  <= 1'b0;
            rst_done_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_dest_q  <= 1'b0;
            cnt_0_q      <= '0;
            cnt_1_q      <= '0;
        end else begin
            state_q      <= state_d;
            lock_dest_q  <= lock_dest_d;
            rst_done_q   <= rst_done_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_dest_q  <= hold_dest_d;
            cnt_0_q      <= cnt_0_d;
            cnt_1_q      <= cnt_1_d;
        end
    end

    // The non-selected output is forced to zero rather than echoing the holding register.
    assign TREADY_in    = ready_in;
    assign TVALID_out_0 = hold_valid_q && !hold_dest_q;
    assign TVALID_out_1 = hold_valid_q &&  hold_dest_q;
    assign DATA_out_0   = hold_dest_q ? '0 : hold_data_q;
    assign DATA_out_1   = hold_dest_q ? hold_data_q : '0;
    assign TLAST_out_0  = !hold_dest_q && hold_last_q;
    assign TLAST_out_1  =  hold_dest_q && hold_last_q;
    assign pkt_cnt_0    = cnt_0_q;
    assign pkt_cnt_1    = cnt_1_q;

endmodule

// File: tb/tb_axis_demux.sv
// Bench for axis_demux: packet-level reference model feeding per-output expectation
// queues, with a negedge monitor popping and comparing on every output handshake.
module tb_axis_demux;

    logic       ACLK;
    logic       ARESETn;
    logic [7:0] DATA_in;
    logic       TVALID_in;
    logic       TLAST_in;
    logic       TREADY_in;
    logic       sel;
    logic [7:0] DATA_out_0, DATA_out_1;
    logic       TVALID_out_0, TVALID_out_1;
    logic       TLAST_out_0, TLAST_out_1;
    logic       TREADY_out_0, TREADY_out_1;
    logic [7:0] pkt_cnt_0, pkt_cnt_1;

    axis_demux #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .DATA_in     (DATA_in),
        .TVALID_in   (TVALID_in),
        .TLAST_in    (TLAST_in),
        .TREADY_in   (TREADY_in),
        .sel         (sel),
        .DATA_out_0  (DATA_out_0),
        .DATA_out_1  (DATA_out_1),
        .TVALID_out_0(TVALID_out_0),
        .TVALID_out_1(TVALID_out_1),
        .TLAST_out_0 (TLAST_out_0),
        .TLAST_out_1 (TLAST_out_1),
        .TREADY_out_0(TREADY_out_0),
        .TREADY_out_1(TREADY_out_1),
        .pkt_cnt_0   (pkt_cnt_0),
        .pkt_cnt_1   (pkt_cnt_1)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    int         n_vec  = 0;
    int         n_fail = 0;
    beat_t      q0[$];
    beat_t      q1[$];
    logic [7:0] exp_cnt0 = 8'd0;
    logic [7:0] exp_cnt1 = 8'd0;
    bit         in_pkt   = 1'b0;
    bit         cur_dest = 1'b0;
    bit         rand_rdy = 1'b0;
    bit         f0 = 1'b1;
    bit         f1 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready generator: forced values or random back-pressure, updated 2 units after each edge.
    initial begin
        TREADY_out_0 = 1'b1;
        TREADY_out_1 = 1'b1;
        forever begin
            @(posedge ACLK);
            #2;
            if (rand_rdy) begin
                TREADY_out_0 = ($urandom_range(0, 3) != 0);
                TREADY_out_1 = ($urandom_range(0, 3) != 0);
            end else begin
                TREADY_out_0 = f0;
                TREADY_out_1 = f1;
            end
        end
    end

    // Monitor and reference model, all sampled mid-cycle.
    initial begin
        bit         stall0 = 1'b0;
        bit         stall1 = 1'b0;
        logic [8:0] sv0 = '0;
        logic [8:0] sv1 = '0;
        beat_t      b;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                q0.delete();
                q1.delete();
                exp_cnt0 = 8'd0;
                exp_cnt1 = 8'd0;
                in_pkt   = 1'b0;
                stall0   = 1'b0;
                stall1   = 1'b0;
            end else begin
                chk("pkt_cnt_0", 32'(pkt_cnt_0), 32'(exp_cnt0));
                chk("pkt_cnt_1", 32'(pkt_cnt_1), 32'(exp_cnt1));
                chk("exclusive_valid", 32'(TVALID_out_0 & TVALID_out_1), 32'd0);
                if (TVALID_out_1) chk("idle_out0_zero", 32'({TLAST_out_0, DATA_out_0}), 32'd0);
                if (TVALID_out_0) chk("idle_out1_zero", 32'({TLAST_out_1, DATA_out_1}), 32'd0);
                if (stall0 && TVALID_out_0) chk("stable_0", 32'({TLAST_out_0, DATA_out_0}), 32'(sv0));
                if (stall1 && TVALID_out_1) chk("stable_1", 32'({TLAST_out_1, DATA_out_1}), 32'(sv1));
                stall0 = TVALID_out_0 && !TREADY_out_0;
                stall1 = TVALID_out_1 && !TREADY_out_1;
                sv0 = {TLAST_out_0, DATA_out_0};
                sv1 = {TLAST_out_1, DATA_out_1};

                if (TVALID_out_0 && q0.size() == 0) chk("spurious_valid_0", 32'(TVALID_out_0), 32'd0);
                if (TVALID_out_1 && q1.size() == 0) chk("spurious_valid_1", 32'(TVALID_out_1), 32'd0);
                if (TVALID_out_0 && TREADY_out_0 && q0.size() != 0) begin
                    b = q0.pop_front();
                    chk("data_0", 32'(DATA_out_0), 32'(b.d));
                    chk("last_0", 32'(TLAST_out_0), 32'(b.l));
                    if (b.l) exp_cnt0 = exp_cnt0 + 8'd1;
                end
                if (TVALID_out_1 && TREADY_out_1 && q1.size() != 0) begin
                    b = q1.pop_front();
                    chk("data_1", 32'(DATA_out_1), 32'(b.d));
                    chk("last_1", 32'(TLAST_out_1), 32'(b.l));
                    if (b.l) exp_cnt1 = exp_cnt1 + 8'd1;
                end

                if (TVALID_in && TREADY_in) begin
                    if (!in_pkt) cur_dest = sel;
                    b.d = DATA_in;
                    b.l = TLAST_in;
                    if (cur_dest) q1.push_back(b);
                    else          q0.push_back(b);
                    in_pkt = !TLAST_in;
                end
            end
        end
    end

    // Callers are at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic s, output int stalls);
        int guard = 0;
        TVALID_in = 1'b1;
        DATA_in   = d;
        TLAST_in  = l;
        sel       = s;
        @(negedge ACLK);
        while (!TREADY_in && guard < 200) begin
            guard++;
            @(negedge ACLK);
        end
        if (guard >= 200) chk("accept_timeout", 32'(TREADY_in), 32'd1);
        stalls = guard;
        @(posedge ACLK);
        #1;
        TVALID_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tready_in"}, 32'(TREADY_in), 32'd0);
        chk({tag, "_valid"}, 32'({TVALID_out_0, TVALID_out_1}), 32'd0);
        chk({tag, "_data"}, 32'({DATA_out_0, DATA_out_1}), 32'd0);
        chk({tag, "_last"}, 32'({TLAST_out_0, TLAST_out_1}), 32'd0);
        chk({tag, "_cnt"}, 32'({pkt_cnt_0, pkt_cnt_1}), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        ARESETn   = 1'b0;
        TVALID_in = 1'b0;
        #1;
        check_zero(tag);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk({tag, "_tready_first_edge"}, 32'(TREADY_in), 32'd0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 500) begin
            @(posedge ACLK);
            #1;
            g++;
        end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        int st;
        int len;
        logic s;
        ARESETn   = 1'b0;
        TVALID_in = 1'b0;
        DATA_in   = 8'd0;
        TLAST_in  = 1'b0;
        sel       = 1'b0;

        repeat (3) @(posedge ACLK);
        #1;
        check_zero("por");
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("por_tready_first_edge", 32'(TREADY_in), 32'd0);
        @(negedge ACLK);
        chk("por_tready_up", 32'(TREADY_in), 32'd1);
        @(posedge ACLK);
        #1;

        // 8-beat packet to output 0
        for (int i = 1; i <= 8; i++) begin
            send_beat(8'(i), (i == 8), 1'b0, st);
            chk("pkt8_no_stall", 32'(st), 32'd0);
        end
        drain();
        chk("pkt8_cnt0", 32'(pkt_cnt_0), 32'd1);
        chk("pkt8_cnt1", 32'(pkt_cnt_1), 32'd0);

        // sel toggling inside a 16-beat packet, then back-to-back switch to output 0
        for (int i = 0; i < 16; i++) begin
            send_beat(8'h40 + 8'(i), (i == 15), (i % 2 == 0), st);
            chk("toggle_no_stall", 32'(st), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h80 + 8'(i), (i == 7), 1'b0, st);
            chk("switch_no_bubble", 32'(st), 32'd0);
        end
        drain();
        chk("toggle_cnt1", 32'(pkt_cnt_1), 32'd1);
        chk("switch_cnt0", 32'(pkt_cnt_0), 32'd2);

        // stall on output 0 with the idle output ready
        f0 = 1'b0;
        f1 = 1'b1;
        send_beat(8'hA5, 1'b0, 1'b0, st);
        TVALID_in = 1'b1;
        DATA_in   = 8'h5A;
        TLAST_in  = 1'b1;
        sel       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("stall_data", 32'(DATA_out_0), 32'hA5);
            chk("stall_valid", 32'(TVALID_out_0), 32'd1);
            chk("stall_tready_in", 32'(TREADY_in), 32'd0);
            @(posedge ACLK);
            #1;
        end
        f0 = 1'b1;
        @(negedge ACLK);
        chk("release_accept", 32'(TREADY_in), 32'd1);
        @(posedge ACLK);
        #1;
        TVALID_in = 1'b0;
        drain();
        chk("stall_cnt0", 32'(pkt_cnt_0), 32'd3);

        // single-beat packets, sel 0,1,1,0
        do_reset("rst_a");
        send_beat(8'h11, 1'b1, 1'b0, st);
        send_beat(8'h22, 1'b1, 1'b1, st);
        send_beat(8'h33, 1'b1, 1'b1, st);
        send_beat(8'h44, 1'b1, 1'b0, st);
        drain();
        chk("single_cnt0", 32'(pkt_cnt_0), 32'd2);
        chk("single_cnt1", 32'(pkt_cnt_1), 32'd2);

        // counter wrap
        do_reset("rst_b");
        for (int i = 0; i < 256; i++) send_beat(8'(i), 1'b1, 1'b1, st);
        drain();
        chk("wrap_cnt1", 32'(pkt_cnt_1), 32'd0);

        // reset mid-packet, then next beat follows current sel
        for (int i = 1; i <= 4; i++) send_beat(8'h10 + 8'(i), 1'b0, 1'b1, st);
        do_reset("rst_mid");
        send_beat(8'hEE, 1'b1, 1'b0, st);
        drain();
        chk("after_rst_cnt0", 32'(pkt_cnt_0), 32'd1);
        chk("after_rst_cnt1", 32'(pkt_cnt_1), 32'd0);

        // randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int p = 0; p < 300; p++) begin
            len = $urandom_range(1, 6);
            s   = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                send_beat(8'($urandom), (j == len - 1), (j == 0) ? s : 1'($urandom_range(0, 1)), st);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge ACLK);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge ACLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
